// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer and the control unit: branch codes,
// sequencer FSM encoding and the default reset address.
package pc_sequencer_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BLEZ = 3'b100;
  localparam logic [2:0] BR_BGTZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition evaluation; combinational, rs_val compared as signed.
// Code 3'b110 is reserved and never taken.
module pc_sequencer_branch_cond
  import pc_sequencer_pkg::*;
(
  input  logic [2:0]  branch,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        cond_true
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    cond_true = 1'b0;
    case (branch)
      BR_BEQ:  cond_true = (rs_val == rt_val);
      BR_BNE:  cond_true = (rs_val != rt_val);
      BR_BGEZ: cond_true = !rs_neg;
      BR_BLEZ: cond_true = rs_neg || rs_zero;
      BR_BGTZ: cond_true = !rs_neg && !rs_zero;
      BR_BLTZ: cond_true = rs_neg;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: FETCH/EXEC handshake with instruction memory and
// next-PC resolution (pc+4, branch target, jump target) with a link value.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic        stall,
  input  logic        jump,
  input  logic [2:0]  branch,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] jindex,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        taken_q, taken_d;

  logic [31:0] pc4;
  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic [31:0] next_pc;
  logic        cond_true;
  logic        redirect;

  pc_sequencer_branch_cond u_branch_cond (
    .branch    (branch),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .cond_true (cond_true)
  );

  assign pc4      = pc_q + 32'd4;
  assign btarget  = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jtarget  = {pc4[31:28], jindex, 2'b00};
  assign redirect = jump || cond_true;
  assign next_pc  = jump ? jtarget : (cond_true ? btarget : pc4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  // ir_load is asserted during the ack cycle so the IR and the state
  // register capture on the same edge.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    taken_d  = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          taken_d = redirect;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc4;
  assign taken     = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// instruction streams checked against an arithmetic next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        ir_load;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [2:0]  branch = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] jindex = 26'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .ir_load   (ir_load),
    .stall     (stall),
    .jump      (jump),
    .branch    (branch),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .imm16     (imm16),
    .jindex    (jindex),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .taken     (taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: next address and redirect flag from the instruction-set rules.
  function automatic logic [32:0] model_next(input logic [31:0] cur, input logic j,
                                             input logic [2:0] br, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [15:0] imm,
                                             input logic [25:0] ji);
    logic [31:0] p4, off, tgt;
    int signed   rs_s;
    logic        c;
    p4   = cur + 32'd4;
    rs_s = rs;
    case (br)
      3'd1:    c = (rs == rt);
      3'd2:    c = (rs != rt);
      3'd3:    c = (rs_s >= 0);
      3'd4:    c = (rs_s <= 0);
      3'd5:    c = (rs_s > 0);
      3'd7:    c = (rs_s < 0);
      default: c = 1'b0;
    endcase
    off = {{16{imm[15]}}, imm} << 2;
    if (j)      tgt = {p4[31:28], ji, 2'b00};
    else if (c) tgt = p4 + off;
    else        tgt = p4;
    return {j | c, tgt};
  endfunction

  // Runs one FETCH/EXEC instruction; entered and left at a negedge in FETCH.
  task automatic do_instr(input logic j, input logic [2:0] br, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] ji,
                          input int ack_dly, input int stl);
    logic [32:0] res;
    imem_ack = 1'b0;
    jump     = 1'($urandom);
    branch   = 3'($urandom);
    rs_val   = $urandom;
    rt_val   = $urandom;
    imm16    = 16'($urandom);
    jindex   = 26'($urandom);
    stall    = 1'($urandom);
    #1;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_pc4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_irload", {31'd0, ir_load}, 32'd0);
      check("wait_taken", {31'd0, taken}, 32'd0);
    end
    imem_ack = 1'b1;
    #1;
    check("ack_irload", {31'd0, ir_load}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'($urandom);
    jump     = j;
    branch   = br;
    rs_val   = rs;
    rt_val   = rt;
    imm16    = imm;
    jindex   = ji;
    stall    = (stl > 0);
    #1;
    check("exec_req", {31'd0, imem_req}, 32'd0);
    check("exec_irload", {31'd0, ir_load}, 32'd0);
    check("exec_taken", {31'd0, taken}, 32'd0);
    check("exec_pc", pc, exp_pc);
    for (int i = 0; i < stl; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == stl - 1) stall = 1'b0;
      #1;
      check("stall_pc", pc, exp_pc);
      check("stall_pc4", pc_plus4, exp_pc + 32'd4);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    res = model_next(exp_pc, j, br, rs, rt, imm, ji);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("next_pc", pc, res[31:0]);
    check("next_taken", {31'd0, taken}, {31'd0, res[32]});
    check("next_req", {31'd0, imem_req}, 32'd1);
    exp_pc = res[31:0];
  endtask

  // Reset asserted at a negedge, optionally with an ack pending.
  task automatic do_reset(input logic ack_pending);
    imem_ack = ack_pending;
    rst      = 1'b1;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_irload", {31'd0, ir_load}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state_req", {31'd0, imem_req}, 32'd0);
    check("rst_state_irload", {31'd0, ir_load}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    exp_pc   = RST_PC;
  endtask

  initial begin
    exp_pc = RST_PC;
    @(negedge clk);
    do_reset(1'b0);

    // sequential fetch 0x0, 0x4, 0x8
    do_instr(1'b0, 3'b000, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 0);
    do_instr(1'b0, 3'b000, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 0);
    check("seq_addr8", imem_addr, 32'h8);
    do_instr(1'b1, 3'b000, 32'd0, 32'd0, 16'h0000, 26'h40, 0, 0);
    check("jmp_0x100", pc, 32'h100);
    do_instr(1'b0, 3'b001, 32'd5, 32'd5, 16'hFFFE, 26'd0, 0, 0);
    check("beq_taken", pc, 32'h0FC);
    do_instr(1'b1, 3'b000, 32'd0, 32'd0, 16'h0000, 26'h40, 0, 0);
    do_instr(1'b0, 3'b001, 32'd5, 32'd6, 16'hFFFE, 26'd0, 0, 0);
    check("beq_not_taken", pc, 32'h104);
    do_instr(1'b0, 3'b111, 32'h8000_0000, 32'd0, 16'h0010, 26'd0, 0, 0);
    do_instr(1'b0, 3'b101, 32'd0, 32'd0, 16'h0010, 26'd0, 1, 0);
    do_instr(1'b0, 3'b110, 32'd7, 32'd7, 16'h0010, 26'd0, 3, 2);
    do_instr(1'b1, 3'b000, 32'd0, 32'd0, 16'h0000, 26'h3FF_FFFF, 0, 0);
    do_instr(1'b0, 3'b000, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 0);
    do_instr(1'b1, 3'b000, 32'd0, 32'd0, 16'h0000, 26'h3FC, 0, 0);
    check("region_pc", pc, 32'h1000_0FF0);
    do_instr(1'b1, 3'b001, 32'd9, 32'd9, 16'h0004, 26'h40, 2, 1);
    check("jump_priority", pc, 32'h1000_0100);

    // reset while fetching with an ack outstanding, then wrap-around
    do_reset(1'b1);
    do_instr(1'b0, 3'b001, 32'd1, 32'd1, 16'hFFFE, 26'd0, 0, 0);
    check("wrap_start", pc, 32'hFFFF_FFFC);
    do_instr(1'b0, 3'b000, 32'd0, 32'd0, 16'h0000, 26'd0, 0, 1);
    check("wrap_zero", pc, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] rs, rt;
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = rs | 32'h8000_0000;
        default: ;
      endcase
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      do_instr(($urandom_range(0, 4) == 0), 3'($urandom), rs, rt, 16'($urandom),
               26'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer that consumes the decoder's Jump/Branch control outputs and produces the next instruction address.
- Owns the PC register and runs an instruction-fetch handshake to instruction memory.
- Resolves all branch/jump types and provides the link address (PC+4) for JAL, BGEZAL and BLTZAL.
- Sits between instruction memory and the control unit in the multicycle datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; always equals pc
imem_ack  input  1  instruction memory has returned the word at imem_addr
ir_load  output  1  one-cycle pulse: latch the fetched instruction into the IR
stall  input  1  hold the EXEC state; PC is not updated
jump  input  1  Jump from control unit
branch  input  3  Branch code from control unit
rs_val  input  32  register-file rs value (signed for compares)
rt_val  input  32  register-file rt value
imm16  input  16  instruction[15:0], branch offset
jindex  input  26  instruction[25:0], jump index
pc  output  32  current PC
pc_plus4  output  32  pc+4, link value for the writeback mux
taken  output  1  one-cycle pulse on the cycle PC is loaded with a branch/jump target

Behaviour:
- Reset (async, applies immediately at any time, including mid-fetch):
  - state=RST, pc=RESET_PC, imem_req=0, ir_load=0, taken=0.
  - Outstanding imem_ack is ignored.
- FSM states and transitions:
  - RST: first clk after rst deasserts -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack=1 -> EXEC, with ir_load=1 on that same cycle (registered, so IR and state update together). imem_ack while not in FETCH is ignored.
  - EXEC: control inputs are valid this cycle. If stall=1, remain in EXEC with no PC change. If stall=0, pc<=next_pc and taken<=redirect (registered; visible for one cycle, concurrent with re-entering FETCH), then -> FETCH.
- Fetch latency: 1 cycle minimum (ack on the first FETCH cycle). Instruction-to-instruction minimum period is 2 cycles (FETCH+EXEC).
- next_pc computation (all arithmetic modulo 2^32, wrap-around silent):
  - pc4 = pc+4.
  - btarget = pc4 + (sign_extend(imm16)<<2).
  - jtarget = {pc4[31:28], jindex, 2'b00}.
  - jump=1 -> jtarget; jump has priority over branch.
  - Otherwise, if branch condition is true -> btarget; else pc4.
  - redirect = jump | cond_true.
- Branch codes (rs_val signed):
  - 000 none
  - 001 BEQ rs==rt
  - 010 BNE rs!=rt
  - 011 BGEZ rs>=0
  - 100 BLEZ rs<=0
  - 101 BGTZ rs>0
  - 111 BLTZ rs<0
  - 110 reserved: treated as none, never taken.
- pc_plus4 is combinational pc+4 and valid in every state. The link value for BGEZAL/BLTZAL is written regardless of taken.
- pc[1:0] is always 00. Targets are aligned by construction.
- Inputs are sampled only in EXEC with stall=0. Values in other states have no effect.

Decomposition:
- Shared package: branch code constants (BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BLEZ, BR_BGTZ, BR_BLTZ), FSM state encoding (RST/FETCH/EXEC), RESET_PC default. The control unit imports the same branch constants.
- One sub-module: branch_cond (combinational; branch, rs_val, rt_val -> cond_true). Everything else stays in pc_sequencer.

Test Plan:
- Reset then sequential fetch: rst pulse, imem_ack=1 each FETCH, branch=000, jump=0 -> imem_addr sequence 0x0, 0x4, 0x8; ir_load pulses every 2nd cycle; taken=0.
- Taken BEQ: pc=0x100, branch=001, rs_val=rt_val=5, imm16=0xFFFE -> pc=0x0FC, taken pulse. Repeat with rt_val=6 -> pc=0x104, no taken pulse.
- Signed compares: branch=111 with rs_val=0x8000_0000 -> taken. branch=101 with rs_val=0 -> not taken. branch=110 with any values -> pc4.
- Jump priority and region: pc=0x1000_0FF0, jump=1, branch=001 (condition true), jindex=0x000_0040 -> pc=0x1000_0100.
- Stall and slow memory: imem_ack held low 3 cycles -> imem_req/imem_addr stable, no ir_load. stall=1 for 2 EXEC cycles -> pc unchanged, pc_plus4 unchanged.
- Reset mid-fetch and wrap: assert rst while in FETCH with ack pending -> imem_req=0 immediately, pc=RESET_PC. pc=0xFFFF_FFFC, no branch -> next pc=0x0000_0000.
